vga_timing_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator. It replaces the fixed hsync/vsync pair with a single pixel-clock-domain block that has programmable geometry, sync polarity, pixel coordinates, frame/line strobes and a runtime-selectable test pattern. The block sits between the board PLL and the VGA DAC pins. It also feeds coordinates to downstream pixel sources.

---
 rtl/vga_timing_gen.sv | 165 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA sync/coordinate generator with four
//               runtime-selectable test patterns, all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CW       = 12,
    parameter int CHK_LOG2 = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_mode,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_active,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic [2:0]    o_rgb
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_BAR_W   = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;

    localparam logic [CW-1:0] c_H_MAX    = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_MAX    = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_H_LAST   = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] c_V_LAST   = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] c_HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] c_BAR_LAST = CW'(c_BAR_W - 1);
    localparam logic          c_HS_ON    = (H_POL != 0);
    localparam logic          c_VS_ON    = (V_POL != 0);

    generate
        if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
            $error("vga_timing_gen: porch and sync widths must be >= 1");
        end
        if (c_H_TOTAL >= (1 << CW) || c_V_TOTAL >= (1 << CW)) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must be < 2**CW");
        end
        if (CW < 6 || CHK_LOG2 >= CW || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_width
            $error("vga_timing_gen: CW/CHK_LOG2/active size out of range");
        end
    endgenerate

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [CW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic [1:0]    mode_q, mode_d;
    logic          first_q, first_d;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_frame;
    logic          w_active;
    logic [5:0]    w_scroll;
    logic [2:0]    w_rgb;

    always_comb begin
        w_h_wrap = (h_q == c_H_MAX);
        w_v_wrap = (v_q == c_V_MAX);
        w_frame  = (h_q == '0) && (v_q == '0);
        w_active = (h_q < c_H_ACT) && (v_q < c_V_ACT);

        h_d = w_h_wrap ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (w_h_wrap) begin
            v_d = w_v_wrap ? '0 : v_q + 1'b1;
        end

        // Mode and frame count for the current frame are resolved at its
        // first pixel, so that pixel already uses the new values.
        mode_d  = w_frame ? i_mode : mode_q;
        fcnt_d  = (w_frame && !first_q) ? fcnt_q + 8'd1 : fcnt_q;
        first_d = first_q && !w_frame;

        // bar_idx_q is the colour for the current h; it saturates at 7.
        bar_idx_d = bar_idx_q;
        bar_cnt_d = bar_cnt_q;
        if (w_h_wrap) begin
            bar_idx_d = 3'd0;
            bar_cnt_d = '0;
        end else if (bar_idx_q != 3'd7) begin
            if (bar_cnt_q == c_BAR_LAST) begin
                bar_idx_d = bar_idx_q + 3'd1;
                bar_cnt_d = '0;
            end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
            end
        end

        // Only bits [5:3] of x+frame are shown, so 6 bits of sum suffice.
        w_scroll = h_q[5:0] + fcnt_d[5:0];

        w_rgb = 3'b000;
        if (w_active) begin
            case (mode_d)
                2'd0:    w_rgb = bar_idx_q;
                2'd1:    w_rgb = {3{h_q[CHK_LOG2] ^ v_q[CHK_LOG2]}};
                2'd2:    w_rgb = (h_q == '0 || h_q == c_H_LAST || v_q == '0 || v_q == c_V_LAST)
                                 ? 3'b111 : 3'b001;
                default: w_rgb = 3'(w_scroll >> 3);
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q           <= '0;
            v_q           <= '0;
            bar_cnt_q     <= '0;
            bar_idx_q     <= 3'd0;
            fcnt_q        <= 8'd0;
            mode_q        <= 2'd0;
            first_q       <= 1'b1;
            o_hsync       <= ~c_HS_ON;
            o_vsync       <= ~c_VS_ON;
            o_active      <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_rgb         <= 3'b000;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            bar_cnt_q     <= bar_cnt_d;
            bar_idx_q     <= bar_idx_d;
            fcnt_q        <= fcnt_d;
            mode_q        <= mode_d;
            first_q       <= first_d;
            o_hsync       <= ((h_q >= c_HS_BEG) && (h_q < c_HS_END)) ? c_HS_ON : ~c_HS_ON;
            o_vsync       <= ((v_q >= c_VS_BEG) && (v_q < c_VS_END)) ? c_VS_ON : ~c_VS_ON;
            o_active      <= w_active;
            o_x           <= w_active ? h_q : '0;
            o_y           <= w_active ? v_q : '0;
            o_line_start  <= (h_q == '0);
            o_frame_start <= w_frame;
            o_rgb         <= w_rgb;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen on two small geometries
//               and one 640-wide geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam logic [31:0] c_M_HS  = 32'h8000_0000;
    localparam logic [31:0] c_M_VS  = 32'h4000_0000;
    localparam logic [31:0] c_M_ACT = 32'h2000_0000;
    localparam logic [31:0] c_M_X   = 32'h1FFE_0000;
    localparam logic [31:0] c_M_Y   = 32'h0001_FFE0;
    localparam logic [31:0] c_M_LS  = 32'h0000_0010;
    localparam logic [31:0] c_M_FS  = 32'h0000_0008;
    localparam logic [31:0] c_M_RGB = 32'h0000_0007;
    localparam int c_FT_S = 98;
    localparam int c_FT_W = 5600;

    typedef struct {
        int          cyc;
        int          inst;
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] mode_s, mode_p, mode_w;
    int   edge_n = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   t      = 0;
    int   epoch  = 0;
    int   lat_s, lat_p, lat_w;
    ent_t sb[$];

    logic hs_s, vs_s, act_s, ls_s, fs_s;
    logic hs_p, vs_p, act_p, ls_p, fs_p;
    logic hs_w, vs_w, act_w, ls_w, fs_w;
    logic [11:0] x_s, y_s, x_p, y_p, x_w, y_w;
    logic [2:0]  rgb_s, rgb_p, rgb_w;
    logic [31:0] out_s, out_p, out_w;

    assign out_s = {hs_s, vs_s, act_s, x_s, y_s, ls_s, fs_s, rgb_s};
    assign out_p = {hs_p, vs_p, act_p, x_p, y_p, ls_p, fs_p, rgb_p};
    assign out_w = {hs_w, vs_w, act_w, x_w, y_w, ls_w, fs_w, rgb_w};

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(0), .V_POL(0)) u_dut_s (
        .i_clk(clk), .i_rst(rst), .i_mode(mode_s),
        .o_hsync(hs_s), .o_vsync(vs_s), .o_active(act_s), .o_x(x_s), .o_y(y_s),
        .o_line_start(ls_s), .o_frame_start(fs_s), .o_rgb(rgb_s));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1), .V_POL(1)) u_dut_p (
        .i_clk(clk), .i_rst(rst), .i_mode(mode_p),
        .o_hsync(hs_p), .o_vsync(vs_p), .o_active(act_p), .o_x(x_p), .o_y(y_p),
        .o_line_start(ls_p), .o_frame_start(fs_p), .o_rgb(rgb_p));

    vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_dut_w (
        .i_clk(clk), .i_rst(rst), .i_mode(mode_w),
        .o_hsync(hs_w), .o_vsync(vs_w), .o_active(act_w), .o_x(x_w), .o_y(y_w),
        .o_line_start(ls_w), .o_frame_start(fs_w), .o_rgb(rgb_w));

    // Closed-form reference: position from cycles since reset release.
    function automatic logic [31:0] model(int ha, int hf, int hsw, int hb,
                                          int va, int vf, int vsw, int vb,
                                          bit hp, bit vp, int tt, int md, int fc);
        int  ht   = ha + hf + hsw + hb;
        int  vt   = va + vf + vsw + vb;
        int  h    = tt % ht;
        int  v    = (tt / ht) % vt;
        bit  act  = (h < ha) && (v < va);
        bit  hs   = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
        bit  vs   = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
        int  rgb  = 0;
        int  bw   = ha / 8;
        logic [11:0] xo = act ? 12'(h) : 12'd0;
        logic [11:0] yo = act ? 12'(v) : 12'd0;
        if (act) begin
            case (md)
                0:       rgb = (h / bw > 7) ? 7 : h / bw;
                1:       rgb = (((h >> 5) ^ (v >> 5)) & 1) != 0 ? 7 : 0;
                2:       rgb = (h == 0 || h == ha - 1 || v == 0 || v == va - 1) ? 7 : 1;
                default: rgb = (((h + fc) % 4096) >> 3) & 7;
            endcase
        end
        return {hs, vs, act, xo, yo, (h == 0), (h == 0 && v == 0), 3'(rgb)};
    endfunction

    task automatic push(int inst, string nm, logic [31:0] m, logic [31:0] e);
        ent_t en;
        en.cyc  = edge_n + 1;
        en.inst = inst;
        en.exp  = e;
        en.mask = m;
        en.name = nm;
        sb.push_back(en);
    endtask

    task automatic directed();
        if (epoch == 0) begin
            if (t == 79)            push(2, "bar0_x79",    c_M_RGB, 32'd0);
            if (t == 80)            push(2, "bar1_x80",    c_M_RGB, 32'd1);
            if (t == 560)           push(2, "bar7_x560",   c_M_RGB, 32'd7);
            if (t == 639)           push(2, "bar7_x639",   c_M_RGB, 32'd7);
            if (t == 640)           push(2, "blank_h640",  c_M_RGB | c_M_ACT, 32'd0);
            if (t == 1750)          push(2, "bars_kept",   c_M_RGB, 32'd1);
            if (t == 3210)          push(2, "blank_v4",    c_M_RGB | c_M_ACT, 32'd0);
            if (t == c_FT_W)        push(2, "chk_x0",      c_M_RGB, 32'd0);
            if (t == c_FT_W + 32)   push(2, "chk_x32",     c_M_RGB, 32'd7);
            if (t == c_FT_W + 64)   push(2, "chk_x64",     c_M_RGB, 32'd0);
        end else begin
            if (t == 0)  push(2, "rst_first_px", c_M_FS | c_M_ACT | c_M_X | c_M_Y | c_M_RGB,
                              c_M_FS | c_M_ACT);
            if (t == 9)  push(0, "hs_pre",  c_M_HS, c_M_HS);
            if (t == 10) push(0, "hs_on0",  c_M_HS, 32'd0);
            if (t == 11) push(0, "hs_on1",  c_M_HS, 32'd0);
            if (t == 12) push(0, "hs_off",  c_M_HS, c_M_HS);
            if (t == 14) push(0, "ls_l1",   c_M_LS, c_M_LS);
            if (t == 15) push(0, "ls_gap",  c_M_LS, 32'd0);
            if (t == 69) push(0, "vs_pre",  c_M_VS, c_M_VS);
            if (t == 70) push(0, "vs_on0",  c_M_VS, 32'd0);
            if (t == 83) push(0, "vs_on13", c_M_VS, 32'd0);
            if (t == 84) push(0, "vs_off",  c_M_VS, c_M_VS);
            if (t == 97) push(0, "fs_gap",  c_M_FS, 32'd0);
            if (t == 98) push(0, "fs_f1",   c_M_FS, c_M_FS);
            if (t == 196) push(0, "fs_f2",  c_M_FS, c_M_FS);
            if (t == 10) push(1, "hsp_on",  c_M_HS, c_M_HS);
            if (t == 12) push(1, "hsp_off", c_M_HS, 32'd0);
            if (t == 70) push(1, "vsp_on",  c_M_VS, c_M_VS);
            if (t == 0)  push(1, "brd_00",  c_M_RGB, 32'd7);
            if (t == 15) push(1, "brd_11",  c_M_RGB, 32'd1);
            if (t == 21) push(1, "brd_71",  c_M_RGB, 32'd7);
            if (t == 7 * c_FT_S)     push(0, "scr_f7",   c_M_RGB, 32'd0);
            if (t == 8 * c_FT_S)     push(0, "scr_f8",   c_M_RGB, 32'd1);
            if (t == 8 * c_FT_S + 7) push(0, "scr_f8x7", c_M_RGB, 32'd1);
            if (t == 63 * c_FT_S)    push(0, "scr_f63",  c_M_RGB, 32'd7);
            if (t == 64 * c_FT_S)    push(0, "scr_f64",  c_M_RGB, 32'd0);
            if (t == 255 * c_FT_S)   push(0, "scr_f255", c_M_RGB, 32'd7);
            if (t == 256 * c_FT_S)   push(0, "scr_wrap", c_M_RGB, 32'd0);
            if (t == 264 * c_FT_S)   push(0, "scr_w8",   c_M_RGB, 32'd1);
        end
    endtask

    // Queue expectations for the edge that samples the current inputs.
    task automatic tick();
        if (rst) begin
            push(0, "rst_s", '1, c_M_HS | c_M_VS);
            push(1, "rst_p", '1, 32'd0);
            push(2, "rst_w", '1, c_M_HS | c_M_VS);
            t = 0;
        end else begin
            if (t % c_FT_S == 0) begin
                lat_s = int'(mode_s);
                lat_p = int'(mode_p);
            end
            if (t % c_FT_W == 0) lat_w = int'(mode_w);
            push(0, "mdl_s", '1, model(8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0, t, lat_s, (t / c_FT_S) % 256));
            push(1, "mdl_p", '1, model(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, t, lat_p, (t / c_FT_S) % 256));
            push(2, "mdl_w", '1, model(640, 16, 96, 48, 4, 1, 1, 1, 1'b0, 1'b0, t, lat_w, (t / c_FT_W) % 256));
            directed();
            t++;
        end
        @(negedge clk);
    endtask

    always begin
        ent_t        en;
        logic [31:0] got;
        @(posedge clk);
        #1;
        while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
            en  = sb.pop_front();
            got = (en.inst == 0) ? out_s : (en.inst == 1) ? out_p : out_w;
            n_chk++;
            if (en.cyc == edge_n && (got & en.mask) === (en.exp & en.mask)) begin
                n_pass++;
            end else begin
                $display("FAIL %s inst=%0d t_cyc=%0d got=%h want=%h mask=%h",
                         en.name, en.inst, en.cyc, got & en.mask, en.exp & en.mask, en.mask);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        mode_s = 2'd3;
        mode_p = 2'd2;
        mode_w = 2'd0;
        lat_s  = 0;
        lat_p  = 0;
        lat_w  = 0;
        repeat (3) tick();
        rst = 1'b0;
        for (int k = 0; k < 13100; k++) begin
            if (k == 1700)  mode_w = 2'd1;
            if (k == 13000) mode_w = 2'd3;
            tick();
        end
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        epoch = 1;
        for (int k = 0; k < 265 * c_FT_S; k++) tick();
        @(posedge clk);
        #3;
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain left=%0d required=0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
